// File: rtl/rx_latency_meter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rx_latency_meter: inline AXI-stream RX latency monitor (min/max/sum/count).
// Optional histogram: RX_LATENCY_HIST_EN.   Revision: 1.0
// ---------------------------------------------------------------------------
module rx_latency_meter #(
   parameter logic [7:0] SR_BASE    = 8'd200,
   parameter logic [7:0] RB_BASE    = 8'd40,
   parameter int         HIST_SHIFT = 4
) (
   input  logic         ce_clk,
   input  logic         ce_rst,
   input  logic [63:0]  vita_time,
   input  logic         set_stb,
   input  logic [7:0]   set_addr,
   input  logic [31:0]  set_data,
   input  logic [7:0]   rb_addr,
   output logic [63:0]  rb_data,
   output logic         rb_stb,
   input  logic [31:0]  s_axis_tdata,
   input  logic [127:0] s_axis_tuser,
   input  logic         s_axis_tlast,
   input  logic         s_axis_tvalid,
   output logic         s_axis_tready,
   output logic [31:0]  m_axis_tdata,
   output logic [127:0] m_axis_tuser,
   output logic         m_axis_tlast,
   output logic         m_axis_tvalid,
   input  logic         m_axis_tready,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t       state;
   logic         sop;
   logic         v1;
   logic [31:0]  diff;
   logic [31:0]  num_pkts;
   logic [31:0]  min_lat;
   logic [31:0]  max_lat;
   logic [63:0]  sum;
   logic [31:0]  count;
   logic [31:0]  err_cnt;
   logic [31:0]  last_lat;

   logic         accept;
   logic         wr_ctrl;
   logic         wr_num;
   logic         ctrl_en;
   logic         ctrl_clr;
   logic         sample_ok;
   logic [31:0]  count_inc;
   logic [64:0]  sum_wide;
   logic [63:0]  sum_inc;
   logic [7:0]   rb_off;
   logic         unused_bits;

   assign m_axis_tdata  = s_axis_tdata;
   assign m_axis_tuser  = s_axis_tuser;
   assign m_axis_tlast  = s_axis_tlast;
   assign m_axis_tvalid = s_axis_tvalid;
   assign s_axis_tready = m_axis_tready;

   assign accept    = s_axis_tvalid & m_axis_tready;
   assign wr_ctrl   = set_stb && (set_addr == SR_BASE);
   assign wr_num    = set_stb && (set_addr == SR_BASE + 8'd1);
   assign ctrl_en   = set_data[0];
   assign ctrl_clr  = wr_ctrl & set_data[1];
   assign sample_ok = v1 & ~diff[31];
   assign count_inc = (count == 32'hFFFF_FFFF) ? count : count + 32'd1;
   assign sum_wide  = {1'b0, sum} + {33'd0, diff};
   assign sum_inc   = sum_wide[64] ? 64'hFFFF_FFFF_FFFF_FFFF : sum_wide[63:0];
   assign rb_off    = rb_addr - RB_BASE;
   assign busy      = (state == RUN);
   assign done      = (state == DONE);
   assign unused_bits = ^vita_time[63:32];

   always_ff @(posedge ce_clk or posedge ce_rst) begin
      if (ce_rst) begin
         sop <= 1'b1;
      end else if (accept) begin
         sop <= s_axis_tlast;
      end
   end

   // Stage 1: capture raw difference of local time and the stamp.
   always_ff @(posedge ce_clk or posedge ce_rst) begin
      if (ce_rst) begin
         v1   <= 1'b0;
         diff <= 32'd0;
      end else begin
         v1 <= (state == RUN) & accept & sop;
         if ((state == RUN) && accept && sop) begin
            diff <= vita_time[31:0] - s_axis_tdata;
         end
      end
   end

   always_ff @(posedge ce_clk or posedge ce_rst) begin
      if (ce_rst) begin
         num_pkts <= 32'd0;
      end else if (wr_num) begin
         num_pkts <= set_data;
      end
   end

   // Stage 2: clear has priority over an update landing in the same cycle.
   always_ff @(posedge ce_clk or posedge ce_rst) begin
      if (ce_rst) begin
         min_lat  <= 32'hFFFF_FFFF;
         max_lat  <= 32'd0;
         sum      <= 64'd0;
         count    <= 32'd0;
         err_cnt  <= 32'd0;
         last_lat <= 32'd0;
      end else if (ctrl_clr) begin
         min_lat  <= 32'hFFFF_FFFF;
         max_lat  <= 32'd0;
         sum      <= 64'd0;
         count    <= 32'd0;
         err_cnt  <= 32'd0;
         last_lat <= 32'd0;
      end else if (v1) begin
         if (diff[31]) begin
            if (err_cnt != 32'hFFFF_FFFF) begin
               err_cnt <= err_cnt + 32'd1;
            end
         end else begin
            last_lat <= diff;
            if (diff < min_lat) min_lat <= diff;
            if (diff > max_lat) max_lat <= diff;
            sum   <= sum_inc;
            count <= count_inc;
         end
      end
   end

   always_ff @(posedge ce_clk or posedge ce_rst) begin
      if (ce_rst) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: if (wr_ctrl && ctrl_en) state <= RUN;
            RUN: begin
               if (wr_ctrl && !ctrl_en) begin
                  state <= IDLE;
               end else if (sample_ok && !ctrl_clr && (num_pkts != 32'd0) &&
                            (count_inc == num_pkts)) begin
                  state <= DONE;
               end
            end
            DONE: if (wr_ctrl && !ctrl_en) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef RX_LATENCY_HIST_EN
   logic [31:0] bins [8];
   logic [31:0] shifted;
   logic [2:0]  hist_idx;

   assign shifted  = diff >> HIST_SHIFT;
   assign hist_idx = (shifted > 32'd7) ? 3'd7 : shifted[2:0];

   always_ff @(posedge ce_clk or posedge ce_rst) begin
      if (ce_rst) begin
         for (int i = 0; i < 8; i++) bins[i] <= 32'd0;
      end else if (ctrl_clr) begin
         for (int i = 0; i < 8; i++) bins[i] <= 32'd0;
      end else if (sample_ok && (bins[hist_idx] != 32'hFFFF_FFFF)) begin
         bins[hist_idx] <= bins[hist_idx] + 32'd1;
      end
   end
`endif

   always_ff @(posedge ce_clk or posedge ce_rst) begin
      if (ce_rst) begin
         rb_data <= 64'd0;
         rb_stb  <= 1'b0;
      end else begin
         rb_stb <= 1'b1;
         case (rb_off)
            8'd0:    rb_data <= {max_lat, min_lat};
            8'd1:    rb_data <= sum;
            8'd2:    rb_data <= {count, err_cnt[29:0], done, busy};
            8'd3:    rb_data <= {32'd0, last_lat};
`ifdef RX_LATENCY_HIST_EN
            8'd4:    rb_data <= {bins[1], bins[0]};
            8'd5:    rb_data <= {bins[3], bins[2]};
            8'd6:    rb_data <= {bins[5], bins[4]};
            8'd7:    rb_data <= {bins[7], bins[6]};
`endif
            default: rb_data <= 64'd0;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rx_latency_meter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rx_latency_meter: directed self-checking bench for rx_latency_meter.
// ---------------------------------------------------------------------------
module tb_rx_latency_meter;

   localparam logic [7:0] SR_CTRL = 8'd200;
   localparam logic [7:0] SR_NUM  = 8'd201;
   localparam logic [7:0] RB      = 8'd40;

   logic         ce_clk = 1'b0;
   logic         ce_rst = 1'b1;
   logic [63:0]  vita_time = 64'd0;
   logic         set_stb = 1'b0;
   logic [7:0]   set_addr = 8'd0;
   logic [31:0]  set_data = 32'd0;
   logic [7:0]   rb_addr = 8'd0;
   logic [63:0]  rb_data;
   logic         rb_stb;
   logic [31:0]  s_axis_tdata = 32'd0;
   logic [127:0] s_axis_tuser = 128'd0;
   logic         s_axis_tlast = 1'b0;
   logic         s_axis_tvalid = 1'b0;
   logic         s_axis_tready;
   logic [31:0]  m_axis_tdata;
   logic [127:0] m_axis_tuser;
   logic         m_axis_tlast;
   logic         m_axis_tvalid;
   logic         m_axis_tready = 1'b1;
   logic         busy;
   logic         done;

   int total = 0;
   int bad   = 0;

   rx_latency_meter dut (
      .ce_clk(ce_clk), .ce_rst(ce_rst), .vita_time(vita_time),
      .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
      .rb_addr(rb_addr), .rb_data(rb_data), .rb_stb(rb_stb),
      .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
      .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
      .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .busy(busy), .done(done)
   );

   always #5 ce_clk = ~ce_clk;

   task automatic idle(input int n);
      repeat (n) @(posedge ce_clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      set_stb = 1'b1; set_addr = a; set_data = d;
      @(posedge ce_clk); #1;
      set_stb = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [63:0] d);
      rb_addr = a;
      @(posedge ce_clk); #1;
      d = rb_data;
   endtask

   task automatic send_beat(input logic [31:0] data, input logic last, input logic [31:0] vt);
      s_axis_tvalid = 1'b1; s_axis_tdata = data; s_axis_tlast = last;
      vita_time = {32'd0, vt};
      @(posedge ce_clk); #1;
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
   endtask

   task automatic test_reset;
      logic [63:0] d;
      total++;
      if (rb_stb !== 1'b0) begin bad++; $display("FAIL rst_rb_stb_in_reset got=%0b exp=0", rb_stb); end
      ce_rst = 1'b0;
      idle(1);
      total++;
      if (rb_stb !== 1'b1) begin bad++; $display("FAIL rst_rb_stb got=%0b exp=1", rb_stb); end
      total++;
      if ({busy, done} !== 2'b00) begin bad++; $display("FAIL rst_busy_done got=%b exp=00", {busy, done}); end
      rd(RB + 8'd0, d);
      total++;
      if (d !== {32'd0, 32'hFFFF_FFFF}) begin bad++; $display("FAIL rst_minmax got=%h exp=%h", d, {32'd0, 32'hFFFF_FFFF}); end
      rd(RB + 8'd1, d);
      total++;
      if (d !== 64'd0) begin bad++; $display("FAIL rst_sum got=%h exp=0", d); end
      rd(RB + 8'd2, d);
      total++;
      if (d !== 64'd0) begin bad++; $display("FAIL rst_status got=%h exp=0", d); end
      rd(RB + 8'd9, d);
      total++;
      if (d !== 64'd0) begin bad++; $display("FAIL rst_bad_addr got=%h exp=0", d); end
   endtask

   task automatic test_single;
      logic [63:0] d;
      wr(SR_CTRL, 32'd1);
      wr(SR_NUM, 32'd0);
      send_beat(32'h100, 1'b0, 32'h130);
      s_axis_tdata = 32'hA5A5_0001; #1;
      total++;
      if (m_axis_tdata !== 32'hA5A5_0001) begin bad++; $display("FAIL passthru_tdata got=%h exp=a5a50001", m_axis_tdata); end
      send_beat(32'h5, 1'b0, 32'h140);
      send_beat(32'h5, 1'b0, 32'h140);
      send_beat(32'h5, 1'b1, 32'h140);
      idle(2);
      rd(RB + 8'd3, d);
      total++;
      if (d !== 64'h30) begin bad++; $display("FAIL single_last got=%h exp=30", d); end
      rd(RB + 8'd0, d);
      total++;
      if (d !== {32'h30, 32'h30}) begin bad++; $display("FAIL single_minmax got=%h exp=%h", d, {32'h30, 32'h30}); end
      rd(RB + 8'd1, d);
      total++;
      if (d !== 64'h30) begin bad++; $display("FAIL single_sum got=%h exp=30", d); end
      rd(RB + 8'd2, d);
      total++;
      if (d !== {32'd1, 30'd0, 2'b01}) begin bad++; $display("FAIL single_status got=%h exp=%h", d, {32'd1, 30'd0, 2'b01}); end
   endtask

   task automatic test_target;
      logic [63:0] d;
      wr(SR_CTRL, 32'd3);
      wr(SR_NUM, 32'd3);
      send_beat(32'h1000, 1'b1, 32'h1005);
      send_beat(32'h2000, 1'b1, 32'h2009);
      send_beat(32'h3000, 1'b1, 32'h3002);
      idle(2);
      total++;
      if ({busy, done} !== 2'b01) begin bad++; $display("FAIL target_pins got=%b exp=01", {busy, done}); end
      rd(RB + 8'd0, d);
      total++;
      if (d !== {32'd9, 32'd2}) begin bad++; $display("FAIL target_minmax got=%h exp=%h", d, {32'd9, 32'd2}); end
      rd(RB + 8'd1, d);
      total++;
      if (d !== 64'd16) begin bad++; $display("FAIL target_sum got=%h exp=10", d); end
      rd(RB + 8'd2, d);
      total++;
      if (d !== {32'd3, 30'd0, 2'b10}) begin bad++; $display("FAIL target_status got=%h exp=%h", d, {32'd3, 30'd0, 2'b10}); end
      send_beat(32'h4000, 1'b1, 32'h4001);
      idle(2);
      rd(RB + 8'd0, d);
      total++;
      if (d !== {32'd9, 32'd2}) begin bad++; $display("FAIL target_fourth got=%h exp=%h", d, {32'd9, 32'd2}); end
   endtask

   task automatic test_wrap;
      logic [63:0] d;
      wr(SR_CTRL, 32'd0);
      wr(SR_NUM, 32'd0);
      wr(SR_CTRL, 32'd3);
      send_beat(32'hFFFF_FFF0, 1'b1, 32'h10);
      send_beat(32'h200, 1'b1, 32'h100);
      idle(2);
      rd(RB + 8'd3, d);
      total++;
      if (d !== 64'h20) begin bad++; $display("FAIL wrap_last got=%h exp=20", d); end
      rd(RB + 8'd2, d);
      total++;
      if (d !== {32'd1, 30'd1, 2'b01}) begin bad++; $display("FAIL wrap_status got=%h exp=%h", d, {32'd1, 30'd1, 2'b01}); end
   endtask

   task automatic test_clear_collision;
      logic [63:0] d;
      send_beat(32'h700, 1'b1, 32'h707);
      wr(SR_CTRL, 32'd3);
      idle(2);
      rd(RB + 8'd0, d);
      total++;
      if (d !== {32'd0, 32'hFFFF_FFFF}) begin bad++; $display("FAIL clr_minmax got=%h exp=%h", d, {32'd0, 32'hFFFF_FFFF}); end
      rd(RB + 8'd2, d);
      total++;
      if (d !== {32'd0, 30'd0, 2'b01}) begin bad++; $display("FAIL clr_status got=%h exp=%h", d, {32'd0, 30'd0, 2'b01}); end
   endtask

   task automatic test_backpressure_reset;
      logic [63:0] d;
      send_beat(32'h300, 1'b0, 32'h304);
      m_axis_tready = 1'b0;
      s_axis_tvalid = 1'b1; s_axis_tdata = 32'h1; vita_time = 64'h50;
      for (int i = 0; i < 5; i++) begin
         #1;
         total++;
         if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL bp_tready cyc=%0d got=%0b exp=0", i, s_axis_tready); end
         @(posedge ce_clk); #1;
      end
      m_axis_tready = 1'b1; s_axis_tlast = 1'b1;
      @(posedge ce_clk); #1;
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
      idle(2);
      rd(RB + 8'd2, d);
      total++;
      if (d !== {32'd1, 30'd0, 2'b01}) begin bad++; $display("FAIL bp_status got=%h exp=%h", d, {32'd1, 30'd0, 2'b01}); end
      rd(RB + 8'd3, d);
      total++;
      if (d !== 64'h4) begin bad++; $display("FAIL bp_last got=%h exp=4", d); end

      send_beat(32'h400, 1'b0, 32'h406);
      send_beat(32'h1, 1'b0, 32'h500);
      ce_rst = 1'b1; #1;
      total++;
      if ({rb_stb, busy, done} !== 3'b000) begin bad++; $display("FAIL mid_rst_pins got=%b exp=000", {rb_stb, busy, done}); end
      total++;
      if (rb_data !== 64'd0) begin bad++; $display("FAIL mid_rst_rb_data got=%h exp=0", rb_data); end
      @(posedge ce_clk); #1;
      ce_rst = 1'b0;
      wr(SR_CTRL, 32'd1);
      send_beat(32'h600, 1'b0, 32'h608);
      idle(2);
      rd(RB + 8'd2, d);
      total++;
      if (d !== {32'd1, 30'd0, 2'b01}) begin bad++; $display("FAIL post_rst_status got=%h exp=%h", d, {32'd1, 30'd0, 2'b01}); end
      rd(RB + 8'd3, d);
      total++;
      if (d !== 64'h8) begin bad++; $display("FAIL post_rst_last got=%h exp=8", d); end
      send_beat(32'h1, 1'b1, 32'h700);
   endtask

   task automatic test_hist;
      logic [63:0] d;
      wr(SR_CTRL, 32'd3);
      send_beat(32'h10, 1'b1, 32'h13);
      send_beat(32'h20, 1'b1, 32'h34);
      send_beat(32'h1000, 1'b1, 32'h11F4);
      idle(2);
`ifdef RX_LATENCY_HIST_EN
      rd(RB + 8'd4, d);
      total++;
      if (d !== {32'd1, 32'd1}) begin bad++; $display("FAIL hist_bin01 got=%h exp=%h", d, {32'd1, 32'd1}); end
      rd(RB + 8'd7, d);
      total++;
      if (d !== {32'd1, 32'd0}) begin bad++; $display("FAIL hist_bin67 got=%h exp=%h", d, {32'd1, 32'd0}); end
`else
      rd(RB + 8'd4, d);
      total++;
      if (d !== 64'd0) begin bad++; $display("FAIL hist_absent got=%h exp=0", d); end
`endif
   endtask

   initial begin
      idle(3);
      test_reset;
      test_single;
      test_target;
      test_wrap;
      test_clear_collision;
      test_backpressure_reset;
      test_hist;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
